// File: rtl/mpu_regs_wr_arbiter.sv
// Round-robin arbiter for the single MPU register-file write port.
// Three writeback sources (ALU, load, host) compete; the winner is latched into a registered write stage.
module mpu_regs_wr_arbiter #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 64
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                halt,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*IDX_W-1:0]  req_idx,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic [5:0]          req_size,
  input  logic [8:0]          req_sel,
  input  logic [8:0]          req_r_sel,
  output logic                we,
  output logic [IDX_W-1:0]    w_idx,
  output logic [DATA_W-1:0]   w_data,
  output logic [1:0]          w_size,
  output logic [2:0]          w_sel,
  output logic [2:0]          w_r_sel,
  output logic [31:0]         wr_pending,
  output logic [1:0]          grant_id
);

  // Handshake: a requester raises valid and holds its fields stable; the transfer
  // happens on the rising edge where valid and ready are both high. Ready never
  // rises without valid, and at most one ready is high in any cycle.

  logic [1:0]        last_q, last_d;
  logic              we_q, we_d;
  logic [1:0]        gid_q, gid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        rsel_q, rsel_d;

  logic [1:0] cand0, cand1, cand2;
  logic       gnt_hit;
  logic [1:0] gnt_id;
  logic       accept;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Lowest priority is written first so the highest-priority valid requester wins.
  always_comb begin
    cand0   = next_id(last_q);
    cand1   = next_id(cand0);
    cand2   = next_id(cand1);
    gnt_hit = 1'b0;
    gnt_id  = 2'd0;
    if (req_valid[cand2]) begin
      gnt_hit = 1'b1;
      gnt_id  = cand2;
    end
    if (req_valid[cand1]) begin
      gnt_hit = 1'b1;
      gnt_id  = cand1;
    end
    if (req_valid[cand0]) begin
      gnt_hit = 1'b1;
      gnt_id  = cand0;
    end
  end

  assign accept    = gnt_hit & ~halt & ~sys_rst;
  assign req_ready = accept ? (3'b001 << gnt_id) : 3'b000;

  always_comb begin
    last_d = last_q;
    we_d   = accept;
    gid_d  = 2'd3;
    idx_d  = idx_q;
    data_d = data_q;
    size_d = size_q;
    sel_d  = sel_q;
    rsel_d = rsel_q;
    if (accept) begin
      last_d = gnt_id;
      gid_d  = gnt_id;
      idx_d  = req_idx[int'(gnt_id)*IDX_W +: IDX_W];
      data_d = req_data[int'(gnt_id)*DATA_W +: DATA_W];
      size_d = req_size[int'(gnt_id)*2 +: 2];
      sel_d  = req_sel[int'(gnt_id)*3 +: 3];
      rsel_d = req_r_sel[int'(gnt_id)*3 +: 3];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_q <= 2'd2;
      we_q   <= 1'b0;
      gid_q  <= 2'd3;
      idx_q  <= '0;
      data_q <= '0;
      size_q <= '0;
      sel_q  <= '0;
      rsel_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      gid_q  <= gid_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      size_q <= size_d;
      sel_q  <= sel_d;
      rsel_q <= rsel_d;
    end
  end

  // Hazard mask and grant id come from the output registers only.
  assign we         = we_q;
  assign w_idx      = idx_q;
  assign w_data     = data_q;
  assign w_size     = size_q;
  assign w_sel      = sel_q;
  assign w_r_sel    = rsel_q;
  assign grant_id   = gid_q;
  assign wr_pending = we_q ? (32'd1 << idx_q) : 32'd0;

endmodule

// File: tb/tb_mpu_regs_wr_arbiter.sv
// Bench for mpu_regs_wr_arbiter: directed scenarios plus randomized traffic
// checked against a queue/array model of the round-robin write arbiter.
module tb_mpu_regs_wr_arbiter;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 64;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                halt;
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*IDX_W-1:0]  req_idx;
  logic [3*DATA_W-1:0] req_data;
  logic [5:0]          req_size;
  logic [8:0]          req_sel;
  logic [8:0]          req_r_sel;
  logic                we;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_data;
  logic [1:0]          w_size;
  logic [2:0]          w_sel;
  logic [2:0]          w_r_sel;
  logic [31:0]         wr_pending;
  logic [1:0]          grant_id;

  always #5 sys_clk = ~sys_clk;

  mpu_regs_wr_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_data(req_data), .req_size(req_size),
    .req_sel(req_sel), .req_r_sel(req_r_sel),
    .we(we), .w_idx(w_idx), .w_data(w_data), .w_size(w_size),
    .w_sel(w_sel), .w_r_sel(w_r_sel), .wr_pending(wr_pending),
    .grant_id(grant_id)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pointer to last winner plus the contents of the write stage.
  int              m_last;
  logic            m_we;
  logic [1:0]      m_gid;
  logic [4:0]      m_idx;
  logic [63:0]     m_data;
  logic [1:0]      m_size;
  logic [2:0]      m_sel;
  logic [2:0]      m_rsel;
  logic [63:0]     rf_model [32];
  logic [63:0]     dut_rf [32];
  logic [1:0]      grant_hist_q[$];

  logic [2:0]   exp_rdy, obs_rdy;
  logic [111:0] exp_out, obs_out;

  // Register file as seen by a reader: captures at the edge while we is high.
  always @(posedge sys_clk) if (we) dut_rf[w_idx] <= w_data;

  function automatic int first_valid();
    for (int k = 1; k <= 3; k++) begin
      if (req_valid[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [111:0] model_out();
    return {m_we, m_gid, m_idx, m_data, m_size, m_sel, m_rsel,
            (m_we ? (32'd1 << m_idx) : 32'd0)};
  endfunction

  task automatic model_reset();
    m_last = 2; m_we = 1'b0; m_gid = 2'd3; m_idx = '0; m_data = '0;
    m_size = '0; m_sel = '0; m_rsel = '0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; req_valid = 3'b000; halt = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int id, input logic [4:0] idx, input logic [63:0] data,
                         input logic [1:0] size, input logic [2:0] sel, input logic [2:0] rsel);
    req_idx[id*IDX_W +: IDX_W]    = idx;
    req_data[id*DATA_W +: DATA_W] = data;
    req_size[id*2 +: 2]           = size;
    req_sel[id*3 +: 3]            = sel;
    req_r_sel[id*3 +: 3]          = rsel;
  endtask

  // One clock: sample ready before the edge, advance model, sample outputs after.
  task automatic step(output int acc);
    int c;
    #1;
    c = first_valid();
    acc = (halt || c < 0) ? -1 : c;
    exp_rdy = (acc < 0) ? 3'b000 : (3'b001 << acc);
    obs_rdy = req_ready;
    @(posedge sys_clk);
    if (m_we) rf_model[m_idx] = m_data;
    if (acc >= 0) begin
      m_last = acc; m_we = 1'b1; m_gid = 2'(acc);
      m_idx  = req_idx[acc*IDX_W +: IDX_W];
      m_data = req_data[acc*DATA_W +: DATA_W];
      m_size = req_size[acc*2 +: 2];
      m_sel  = req_sel[acc*3 +: 3];
      m_rsel = req_r_sel[acc*3 +: 3];
    end else begin
      m_we = 1'b0; m_gid = 2'd3;
    end
    #1;
    exp_out = model_out();
    obs_out = {we, grant_id, w_idx, w_data, w_size, w_sel, w_r_sel, wr_pending};
    grant_hist_q.push_back(grant_id);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; halt = 1'b0; req_valid = 3'b111;
    #3;
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready act=%b exp=000", req_ready); end
    @(posedge sys_clk); #1;
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we act=%b exp=0", we); end
    n_vec++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL reset_gid act=%0d exp=3", grant_id); end
    n_vec++; if (wr_pending !== 32'd0) begin n_err++; $display("FAIL reset_pend act=%h exp=0", wr_pending); end
    n_vec++; if ({w_idx, w_data, w_size, w_sel, w_r_sel} !== '0) begin
      n_err++; $display("FAIL reset_fields act=%h exp=0", {w_idx, w_data, w_size, w_sel, w_r_sel});
    end
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready2 act=%b exp=000", req_ready); end
    @(negedge sys_clk);
    sys_rst = 1'b0; req_valid = 3'b000;
    model_reset();
  endtask

  task automatic test_single();
    int acc;
    set_req(0, 5'd0, 64'haaaaaaaaaaaaaaaa, 2'd0, 3'd0, 3'd0);
    req_valid = 3'b001;
    for (int i = 0; i < 2; i++) begin
      step(acc);
      req_valid = 3'b000;
      n_vec++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL single_ready act=%b exp=%b", obs_rdy, exp_rdy); end
      n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL single_out act=%h exp=%h", obs_out, exp_out); end
    end
  endtask

  task automatic test_round_robin();
    int acc;
    apply_reset();
    for (int r = 0; r < 3; r++) set_req(r, 5'(r + 1), {$urandom, $urandom}, 2'(r), 3'(r), 3'(r));
    req_valid = 3'b111;
    grant_hist_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(acc);
      n_vec++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL rr_ready act=%b exp=%b", obs_rdy, exp_rdy); end
      n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL rr_out act=%h exp=%h", obs_out, exp_out); end
      n_vec++; if (grant_hist_q[i] !== 2'(i % 3) || w_idx !== 5'(i % 3 + 1)) begin
        n_err++; $display("FAIL rr_order act=%0d/%0d exp=%0d/%0d", grant_hist_q[i], w_idx, i % 3, i % 3 + 1);
      end
    end
    req_valid = 3'b000;
    step(acc);
    n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL rr_idle act=%h exp=%h", obs_out, exp_out); end
  endtask

  task automatic test_load_hold();
    int acc;
    int load_step;
    load_step = 99;
    set_req(1, 5'd1, 64'hbbbbbbbbbbbbbbbb, 2'd1, 3'd2, 3'd2);
    set_req(0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 2'd0, 3'd0, 3'd0);
    req_valid = 3'b011;
    for (int i = 1; i <= 4; i++) begin
      step(acc);
      n_vec++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL load_ready act=%b exp=%b", obs_rdy, exp_rdy); end
      n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL load_out act=%h exp=%h", obs_out, exp_out); end
      if (acc == 0) set_req(0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 2'd0, 3'd0, 3'd0);
      if (acc == 1) begin
        load_step = i;
        req_valid[1] = 1'b0;
        n_vec++; if ({w_size, w_sel, w_r_sel, wr_pending} !== {2'd1, 3'd2, 3'd2, 32'h2}) begin
          n_err++; $display("FAIL load_fields act=%h exp=%h", {w_size, w_sel, w_r_sel, wr_pending}, {2'd1, 3'd2, 3'd2, 32'h2});
        end
      end
    end
    n_vec++; if (load_step > 2) begin n_err++; $display("FAIL load_latency act=%0d exp<=2", load_step); end
    req_valid = 3'b000;
    step(acc);
  endtask

  task automatic test_halt();
    int acc;
    int last_before;
    for (int r = 0; r < 3; r++) set_req(r, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 2'(r), 3'(r), 3'(r));
    req_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      halt = (i >= 1 && i <= 3);
      last_before = m_last;
      step(acc);
      n_vec++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL halt_ready act=%b exp=%b", obs_rdy, exp_rdy); end
      n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL halt_out act=%h exp=%h", obs_out, exp_out); end
      if (i == 4) begin
        n_vec++; if (grant_id !== 2'((last_before + 1) % 3)) begin
          n_err++; $display("FAIL halt_resume act=%0d exp=%0d", grant_id, (last_before + 1) % 3);
        end
      end
    end
    halt = 1'b0; req_valid = 3'b000;
    step(acc);
  endtask

  task automatic test_same_target();
    int acc;
    logic [1:0] g [2];
    set_req(0, 5'd5, 64'h1111111111111111, 2'd0, 3'd0, 3'd0);
    set_req(2, 5'd5, 64'h2222222222222222, 2'd0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      req_valid = (i == 0) ? 3'b001 : (i == 1) ? 3'b100 : 3'b000;
      step(acc);
      if (i < 2) g[i] = grant_id;
      n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL same_out act=%h exp=%h", obs_out, exp_out); end
    end
    n_vec++; if (g[0] !== 2'd0 || g[1] !== 2'd2) begin n_err++; $display("FAIL same_order act=%0d,%0d exp=0,2", g[0], g[1]); end
    n_vec++; if (dut_rf[5] !== 64'h2222222222222222) begin
      n_err++; $display("FAIL same_r5 act=%h exp=2222222222222222", dut_rf[5]);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    for (int r = 0; r < 3; r++) set_req(r, 5'(r + 8), {$urandom, $urandom}, 2'd0, 3'd0, 3'd0);
    req_valid = 3'b010;
    step(acc);
    n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL rstmid_pre act=%b exp=1", we); end
    #1 sys_rst = 1'b1;
    #1;
    n_vec++; if ({we, grant_id, wr_pending} !== {1'b0, 2'd3, 32'd0}) begin
      n_err++; $display("FAIL rstmid_async act=%h exp=%h", {we, grant_id, wr_pending}, {1'b0, 2'd3, 32'd0});
    end
    model_reset();
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    req_valid = 3'b111;
    step(acc);
    n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL rstmid_out act=%h exp=%h", obs_out, exp_out); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rstmid_winner act=%0d exp=0", grant_id); end
    req_valid = 3'b000;
    step(acc);
  endtask

  task automatic test_random();
    int acc;
    int others [3];
    for (int r = 0; r < 3; r++) others[r] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (!req_valid[r] && $urandom_range(0, 99) < 45) begin
          set_req(r, 5'($urandom_range(0, 7)), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
          req_valid[r] = 1'b1;
          others[r] = 0;
        end
      end
      halt = ($urandom_range(0, 9) == 0);
      step(acc);
      n_vec++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL rand_ready cyc=%0d act=%b exp=%b", cyc, obs_rdy, exp_rdy); end
      n_vec++; if (obs_out !== exp_out) begin n_err++; $display("FAIL rand_out cyc=%0d act=%h exp=%h", cyc, obs_out, exp_out); end
      if (acc >= 0) begin
        n_vec++; if (others[acc] > 2) begin n_err++; $display("FAIL rand_fair req=%0d act=%0d exp<=2", acc, others[acc]); end
        req_valid[acc] = 1'b0;
        for (int r = 0; r < 3; r++) if (r != acc && req_valid[r]) others[r]++;
      end
    end
    halt = 1'b0; req_valid = 3'b000;
    repeat (2) step(acc);
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (dut_rf[i] !== rf_model[i]) begin n_err++; $display("FAIL rand_rf r%0d act=%h exp=%h", i, dut_rf[i], rf_model[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      dut_rf[i]   = '0;
    end
    req_idx = '0; req_data = '0; req_size = '0; req_sel = '0; req_r_sel = '0;
    req_valid = 3'b000; halt = 1'b0; sys_rst = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_load_hold();
    test_halt();
    test_same_target();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpu_regs_wr_arbiter.md
# mpu_regs_wr_arbiter

Round-robin arbiter sharing the single write port of the MPU register file (32 × 64-bit, four read ports) between three writeback sources: ALU result, load unit and host/debug port. Accepts at most one write per cycle over valid/ready handshakes. Drives the register file write port from a registered output stage. Exports a one-hot pending-write mask for read-hazard checks in the issue logic.

## Interface
- IDX_W, 5, register index width (32 registers)
- DATA_W, 64, write data width
- sys_clk  in  1  system clock, all state on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- halt  in  1  freeze: while high, no request is accepted
- req_valid  in  3  per-requester valid (bit 0 ALU, 1 load, 2 host)
- req_ready  out  3  per-requester ready, one-hot or zero
- req_idx  in  3×IDX_W  packed target indices, requester i at [i*5+:5]
- req_data  in  3×DATA_W  packed write data, requester i at [i*64+:64]
- req_size  in  3×2  packed sub-word size, same encoding as register file w_size
- req_sel  in  3×3  packed destination lane select (w_sel)
- req_r_sel  in  3×3  packed source lane select (w_r_sel)
- we  out  1  register file write enable
- w_idx  out  IDX_W  register file write index
- w_data  out  DATA_W  register file write data
- w_size, w_sel, w_r_sel  out  2/3/3  forwarded sub-word controls
- wr_pending  out  32  one-hot of w_idx when we=1, else 0
- grant_id  out  2  requester that owns the current we cycle (0..2), 3 when idle

## Operation
- Arbitration is combinational each cycle. The priority order starts at (last+1) mod 3, where last is the most recently accepted requester.
- req_ready[i] = ~halt & req_valid[i] & (i is the first valid requester in priority order).
- req_ready never asserts without its own valid.
- Acceptance happens when req_valid[i] & req_ready[i]. The `last` pointer updates to i only on acceptance.
- On acceptance, the fields of requester i are latched into the output stage. Next cycle: we=1 and grant_id=i.
- With no acceptance: we=0, and grant_id=3 next cycle. w_idx, w_data, w_size, w_sel and w_r_sel hold their previous values.
- The output stage is always free (the register file never stalls), so sustained throughput is one write per cycle.
- Fairness: a requester holding valid high is granted within 3 cycles of accepted traffic. Starvation is impossible.
- halt overrides everything: all ready=0, `last` unchanged. A write already latched still completes on the following cycle.
- Requesters must hold valid and fields stable until accepted. A dropped valid is not an error; the request is simply never accepted.
- No merging or reordering of writes. Writes are issued in acceptance order.
- Two requesters targeting the same index are serialised. The later-accepted write wins.

## Timing
- Reset values: we=0, w_idx=0, w_data=0, w_size=0, w_sel=0, w_r_sel=0, wr_pending=0, grant_id=3, last=2 (requester 0 has top priority after reset).
- req_ready reads 0 while sys_rst is high.
- Latency: accept at edge N, then we=1 during cycle N→N+1. The register file captures the write at edge N+1.
- Back-to-back: accepts at consecutive edges produce we high continuously, with fields changing every cycle.
- Reset mid-operation: a latched but not yet written entry is discarded (we forced 0 asynchronously). The pointer returns to last=2.
- wr_pending and grant_id are combinational from output-stage registers only. They have no path from the req_* inputs.

## Test plan
- Reset then single request: after sys_rst releases, ALU drives idx=0, data=0xaaaaaaaaaaaaaaaa, sel=0, r_sel=0, size=0 → ready[0] high in the same cycle. Next cycle: we=1, w_idx=0, wr_pending=0x00000001, grant_id=0. The cycle after: we=0, grant_id=3.
- All three valid for 6 cycles (idx 1, 2, 3) → grant order 0,1,2,0,1,2; we high for 6 consecutive cycles; w_idx sequence 1,2,3,1,2,3.
- Load holds idx=1, data=0xbbbbbbbbbbbbbbbb, sel=2, r_sel=2, size=1 while ALU streams → load accepted by the second cycle. Output shows w_size=1, w_sel=2, w_r_sel=2, wr_pending=0x00000002.
- halt asserted for 3 cycles with all valid → ready=0 throughout. A write latched before halt appears once. After release, arbitration resumes from the unchanged pointer.
- Same target: ALU then host both write idx=5 with 0x1111… and 0x2222… → two we cycles, host second. A reader of r5 sees 0x2222….
- Reset pulse while we=1 → we drops to 0 without waiting for a clock edge, grant_id=3. After release, requester 0 wins a three-way contest.
